// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions used by the hazard controller and the control unit.
//   REG_W        register-id width (16 architectural registers)
//   RA_REG       return-address register (r15), destination of call
//   FWD_*        EX operand-forwarding select encodings
//   div_state_t  multi-cycle div/mod occupancy FSM states
//   OP_*         5-bit opcodes shared with the control unit
package simplerisc_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] RA_REG = 4'd15;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MA = 2'b01;
  localparam logic [1:0] FWD_RW = 2'b10;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  // Control-unit helper: opcodes that occupy EX for more than one cycle.
  function automatic logic is_multi_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath/control unit and
// pipeline_hazard_ctrl.
//   master: the pipeline; drives OF instruction info and the EX branch outcome,
//           receives latch/PC controls and forwarding selects.
//   slave : the hazard controller.
interface pipeline_hazard_ctrl_if;
  import simplerisc_pkg::*;

  // OF-stage instruction summary
  logic             of_valid;
  logic [REG_W-1:0] of_rs1;
  logic [REG_W-1:0] of_rs2;
  logic             of_use_rs1;
  logic             of_use_rs2;
  logic [REG_W-1:0] of_rd;
  logic             of_is_wb;
  logic             of_is_ld;
  logic             of_is_multi;
  // EX-stage branch resolution
  logic             ex_branch_taken;
  // Latch / PC controls
  logic             pc_stall;
  logic             ifof_stall;
  logic             ifof_flush;
  logic             ofex_bubble;
  logic             ex_hold;
  logic             exma_bubble;
  // Forwarding / bypass selects
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             of_byp_a;
  logic             of_byp_b;
  logic             div_busy;

  modport master (
    output of_valid, of_rs1, of_rs2, of_use_rs1, of_use_rs2, of_rd,
           of_is_wb, of_is_ld, of_is_multi, ex_branch_taken,
    input  pc_stall, ifof_stall, ifof_flush, ofex_bubble, ex_hold,
           exma_bubble, fwd_a_sel, fwd_b_sel, of_byp_a, of_byp_b, div_busy
  );

  modport slave (
    input  of_valid, of_rs1, of_rs2, of_use_rs1, of_use_rs2, of_rd,
           of_is_wb, of_is_ld, of_is_multi, ex_branch_taken,
    output pc_stall, ifof_stall, ifof_flush, ofex_bubble, ex_hold,
           exma_bubble, fwd_a_sel, fwd_b_sel, of_byp_a, of_byp_b, div_busy
  );

endinterface

// File: rtl/hazard_shadow_stage.sv
// One shadow-pipeline register slice (valid bit + W-bit payload).
//   clk, reset : clock, asynchronous active-high clear
//   hold       : keep current contents (wins over bubble/load)
//   bubble     : load an invalid entry
//   d_v, d     : incoming valid and payload
//   q_v, q     : registered valid and payload
module hazard_shadow_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         bubble,
  input  logic         d_v,
  input  logic [W-1:0] d,
  output logic         q_v,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_v <= 1'b0;
      q   <= '0;
    end else if (!hold) begin
      // A bubble only needs the valid cleared; the payload is don't-care.
      q_v <= d_v & ~bubble;
      q   <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock, forwarding and flush controller for the five-stage SimpleRisc
// pipeline (predict not-taken, no delay slots).
//   clk    : clock
//   reset  : asynchronous active-high reset
//   hz     : slave side of pipeline_hazard_ctrl_if (OF instruction info and
//            branch outcome in; PC/latch controls, forwarding selects and
//            div_busy out)
// Parameter DIV_LAT: cycles a div/mod occupies EX (1 = single cycle).
// The register-id width REG_W comes from simplerisc_pkg.
module pipeline_hazard_ctrl
  import simplerisc_pkg::*;
#(
  parameter int DIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam int EX_W  = 3 * REG_W + 4;  // rd, rs1, rs2, wb, ld, use1, use2
  localparam int MA_W  = REG_W + 2;      // rd, wb, ld
  localparam int RW_W  = REG_W + 1;      // rd, wb

  // Youngest producer wins: MA (non-load) before RW.
  function automatic logic [1:0] fwd_sel(
    input logic             src_v,
    input logic             src_use,
    input logic [REG_W-1:0] src,
    input logic             ma_v_i,
    input logic             ma_wb_i,
    input logic             ma_ld_i,
    input logic [REG_W-1:0] ma_rd_i,
    input logic             rw_v_i,
    input logic             rw_wb_i,
    input logic [REG_W-1:0] rw_rd_i
  );
    if (src_v && src_use && ma_v_i && ma_wb_i && !ma_ld_i && (ma_rd_i == src))
      return FWD_MA;
    else if (src_v && src_use && rw_v_i && rw_wb_i && (rw_rd_i == src))
      return FWD_RW;
    else
      return FWD_RF;
  endfunction

  logic             ex_v, ma_v, rw_v;
  logic [EX_W-1:0]  ex_q;
  logic [MA_W-1:0]  ma_q;
  logic [RW_W-1:0]  rw_q;
  logic [REG_W-1:0] ex_rd, ex_rs1, ex_rs2, ma_rd, rw_rd;
  logic             ex_wb, ex_ld, ex_use1, ex_use2, ma_wb, ma_ld, rw_wb;

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             div_busy, taken, load_use, stall_lu, advance;

  assign {ex_rd, ex_rs1, ex_rs2, ex_wb, ex_ld, ex_use1, ex_use2} = ex_q;
  assign {ma_rd, ma_wb, ma_ld} = ma_q;
  assign {rw_rd, rw_wb}        = rw_q;

  assign div_busy = (state == DIV_BUSY);
  // A taken branch can only come from a real instruction in EX; this also
  // keeps every output low while the shadows are empty after reset.
  assign taken    = hz.ex_branch_taken & ex_v & ~div_busy;
  assign load_use = hz.of_valid & ex_v & ex_ld & ex_wb &
                    ((hz.of_use_rs1 & (hz.of_rs1 == ex_rd)) |
                     (hz.of_use_rs2 & (hz.of_rs2 == ex_rd)));
  assign stall_lu = load_use & ~div_busy & ~taken;
  assign advance  = ~div_busy & ~taken & ~load_use;

  // ---- OF -> EX shadow boundary
  hazard_shadow_stage #(.W(EX_W)) u_ex (
    .clk    (clk),
    .reset  (reset),
    .hold   (div_busy),
    .bubble (taken | load_use),
    .d_v    (hz.of_valid),
    .d      ({hz.of_rd, hz.of_rs1, hz.of_rs2, hz.of_is_wb, hz.of_is_ld,
              hz.of_use_rs1, hz.of_use_rs2}),
    .q_v    (ex_v),
    .q      (ex_q)
  );

  // ---- EX -> MA shadow boundary
  hazard_shadow_stage #(.W(MA_W)) u_ma (
    .clk    (clk),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (div_busy),
    .d_v    (ex_v),
    .d      ({ex_rd, ex_wb, ex_ld}),
    .q_v    (ma_v),
    .q      (ma_q)
  );

  // ---- MA -> RW shadow boundary
  hazard_shadow_stage #(.W(RW_W)) u_rw (
    .clk    (clk),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (1'b0),
    .d_v    (ma_v),
    .d      ({ma_rd, ma_wb}),
    .q_v    (rw_v),
    .q      (rw_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The op spends one IDLE cycle in EX after BUSY, so loading DIV_LAT-1
  // gives exactly DIV_LAT cycles of EX occupancy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      DIV_IDLE: begin
        if (advance && hz.of_valid && hz.of_is_multi && (DIV_LAT > 1)) begin
          state_nxt = DIV_BUSY;
          cnt_nxt   = CNT_W'(DIV_LAT - 1);
        end
      end
      DIV_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DIV_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DIV_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    hz.pc_stall    = div_busy | stall_lu;
    hz.ifof_stall  = div_busy | stall_lu;
    hz.ifof_flush  = taken;
    hz.ofex_bubble = taken | stall_lu;
    hz.ex_hold     = div_busy;
    hz.exma_bubble = div_busy;
    hz.div_busy    = div_busy;
    hz.fwd_a_sel   = fwd_sel(ex_v, ex_use1, ex_rs1, ma_v, ma_wb, ma_ld, ma_rd,
                             rw_v, rw_wb, rw_rd);
    hz.fwd_b_sel   = fwd_sel(ex_v, ex_use2, ex_rs2, ma_v, ma_wb, ma_ld, ma_rd,
                             rw_v, rw_wb, rw_rd);
    // Distance-3 producer writes the RF in the same cycle OF reads it.
    hz.of_byp_a    = hz.of_valid & hz.of_use_rs1 & rw_v & rw_wb & (rw_rd == hz.of_rs1);
    hz.of_byp_b    = hz.of_valid & hz.of_use_rs2 & rw_v & rw_wb & (rw_rd == hz.of_rs2);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DIV_LAT = 4). Outputs are packed as
// {pc_stall, ifof_stall, ifof_flush, ofex_bubble, ex_hold, exma_bubble,
//  div_busy, of_byp_a, of_byp_b, fwd_a_sel[1:0], fwd_b_sel[1:0]}.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.DIV_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {hz.pc_stall, hz.ifof_stall, hz.ifof_flush, hz.ofex_bubble,
                hz.ex_hold, hz.exma_bubble, hz.div_busy, hz.of_byp_a,
                hz.of_byp_b, hz.fwd_a_sel, hz.fwd_b_sel};

  function automatic logic [12:0] mk(
    input logic ps, input logic is, input logic fl, input logic ob,
    input logic eh, input logic eb, input logic db, input logic ba,
    input logic bb, input logic [1:0] fa, input logic [1:0] fb);
    return {ps, is, fl, ob, eh, eb, db, ba, bb, fa, fb};
  endfunction

  task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic op(input logic v, input logic [3:0] rd, input logic [3:0] rs1,
                    input logic [3:0] rs2, input logic u1, input logic u2,
                    input logic wb, input logic ld, input logic mul);
    hz.of_valid    = v;
    hz.of_rd       = rd;
    hz.of_rs1      = rs1;
    hz.of_rs2      = rs2;
    hz.of_use_rs1  = u1;
    hz.of_use_rs2  = u2;
    hz.of_is_wb    = wb;
    hz.of_is_ld    = ld;
    hz.of_is_multi = mul;
  endtask

  task automatic nop_in();
    op(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    op(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ld_op(input logic [3:0] rd, input logic [3:0] rs1);
    op(1'b1, rd, rs1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic div_op(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    op(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // Each call spans one cycle, starting and ending 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [12:0] exp);
    @(negedge clk);
    check_val(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop_in();
    hz.ex_branch_taken = 1'b0;
    repeat (3) tick();
  endtask

  logic [12:0] z, stall_lu, busy;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    z        = '0;
    stall_lu = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    busy     = mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);

    // Reset: outputs low while held and in the first cycle after release
    reset = 1'b1;
    hz.ex_branch_taken = 1'b1;
    alu(4'd1, 4'd2, 4'd3);
    tick_chk("reset_hold", z);
    reset = 1'b0;
    hz.ex_branch_taken = 1'b0;
    nop_in();
    tick_chk("reset_release", z);

    // add r1,r2,r3 ; sub r4,r1,r5
    alu(4'd1, 4'd2, 4'd3);  tick_chk("t1_add_of", z);
    alu(4'd4, 4'd1, 4'd5);  tick_chk("t1_sub_of", z);
    nop_in();               tick_chk("t1_fwd_ma", mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00));
    drain();

    // ld r1,0[r2] ; add r3,r1,r4
    ld_op(4'd1, 4'd2);      tick_chk("t2_ld_of", z);
    alu(4'd3, 4'd1, 4'd4);  tick_chk("t2_load_use", stall_lu);
                            tick_chk("t2_bubble", z);
    nop_in();               tick_chk("t2_fwd_rw", mk(0,0,0,0,0,0,0,0,0, 2'b10, 2'b00));
    drain();

    // div r5,r6,r7 ; add r8,r5,r1
    div_op(4'd5, 4'd6, 4'd7); tick_chk("t3_div_of", z);
    alu(4'd8, 4'd5, 4'd1);
    tick_chk("t3_busy1", busy);
    tick_chk("t3_busy2", busy);
    tick_chk("t3_busy3", busy);
    tick_chk("t3_div_last", z);
    nop_in();               tick_chk("t3_fwd_ma", mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00));
    drain();

    // Taken branch in EX coinciding with a load-use consumer in OF
    ld_op(4'd1, 4'd2);      tick_chk("t4_ld_of", z);
    alu(4'd3, 4'd1, 4'd4);
    hz.ex_branch_taken = 1'b1;
    tick_chk("t4_flush", mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    hz.ex_branch_taken = 1'b0;
    tick_chk("t4_ex_empty", z);
    drain();

    // add r1 ; nop ; nop ; sub r2,r1,r3
    alu(4'd1, 4'd2, 4'd3);  tick_chk("t5_add_of", z);
    nop_in();               tick(); tick();
    alu(4'd2, 4'd1, 4'd3);  tick_chk("t5_of_byp", mk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00));
    nop_in();               tick_chk("t5_fwd_none", z);
    drain();

    // Two producers of r1 in flight: MA beats RW on both operands
    alu(4'd1, 4'd2, 4'd3);  tick();
    alu(4'd1, 4'd4, 4'd5);  tick();
    alu(4'd4, 4'd1, 4'd1);  tick_chk("t6_sub_of", z);
    nop_in();               tick_chk("t6_youngest", mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b01));
    drain();

    // Operand B forwarded from RW
    alu(4'd1, 4'd2, 4'd3);  tick();
    nop_in();               tick();
    alu(4'd4, 4'd5, 4'd1);  tick_chk("t7_sub_of", z);
    nop_in();               tick_chk("t7_fwd_b_rw", mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b10));
    drain();

    // Store data (rs2) takes the RW write-data bypass in OF
    alu(4'd9, 4'd2, 4'd3);  tick();
    nop_in();               tick(); tick();
    op(1'b1, 4'd0, 4'd4, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk("t8_byp_b", mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00));
    drain();

    // Load feeding store data (rs2) interlocks
    ld_op(4'd9, 4'd2);      tick();
    op(1'b1, 4'd0, 4'd4, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk("t9_load_use_b", stall_lu);
    drain();

    // Reset asserted on the second busy cycle of a div
    div_op(4'd5, 4'd6, 4'd7); tick();
    alu(4'd8, 4'd5, 4'd1);    tick_chk("t10_busy1", busy);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("t10_async_clear", obs, z);
    @(posedge clk);
    #1 reset = 1'b0;
    tick_chk("t10_after_rel", z);
    nop_in();                 tick_chk("t10_empty", z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
